// File: rtl/anthem_char_receiver.sv
// Character receiver: buffers ASCII bytes in a small FIFO and shows each one
// on a 7-segment display for HOLD enabled cycles, back-to-back when queued.
module anthem_char_receiver #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [7:0]               seg_out,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_seg, w_seg_nxt;
    logic [HW-1:0]   r_hold, w_hold_nxt;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [7:0]      r_mem [DEPTH];
    logic            r_busy, r_ovf;
    logic            w_push, w_pop, w_nonempty;
    logic [7:0]      w_head;

    function automatic logic [7:0] decode(input logic [7:0] ch);
        case (ch)
            8'h30: decode = 8'h3F;  8'h31: decode = 8'h06;
            8'h32: decode = 8'h5B;  8'h33: decode = 8'h4F;
            8'h34: decode = 8'h66;  8'h35: decode = 8'h6D;
            8'h36: decode = 8'h7D;  8'h37: decode = 8'h07;
            8'h38: decode = 8'h7F;  8'h39: decode = 8'h6F;
            8'h41, 8'h61: decode = 8'h77;
            8'h42, 8'h62: decode = 8'h7C;
            8'h43, 8'h63: decode = 8'h39;
            8'h44, 8'h64: decode = 8'h5E;
            8'h45, 8'h65: decode = 8'h79;
            8'h46, 8'h66: decode = 8'h71;
            8'h20: decode = 8'h00;
            8'h2D: decode = 8'h40;
            default: decode = 8'hC9;   // three bars + dp: unsupported glyph
        endcase
    endfunction

    // Ready comes from the registered count only, so a pop never frees a slot
    // for a push in the same cycle.
    assign rx_ready   = (r_count != CW'(DEPTH));
    assign w_push     = rx_valid && rx_ready;
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_mem[r_rptr];

    always_comb begin
        w_state_nxt = r_state;
        w_seg_nxt   = r_seg;
        w_hold_nxt  = r_hold;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_seg_nxt = 8'h00;
                if (ena && w_nonempty) begin
                    w_pop       = 1'b1;
                    w_seg_nxt   = decode(w_head);
                    w_hold_nxt  = HW'(HOLD - 1);
                    w_state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (ena) begin
                    if (r_hold != '0) begin
                        w_hold_nxt = r_hold - HW'(1);
                    end else if (w_nonempty) begin
                        w_pop      = 1'b1;
                        w_seg_nxt  = decode(w_head);
                        w_hold_nxt = HW'(HOLD - 1);
                    end else begin
                        w_seg_nxt   = 8'h00;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_seg   <= 8'h00;
            r_hold  <= '0;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_seg   <= w_seg_nxt;
            r_hold  <= w_hold_nxt;
            r_busy  <= (w_state_nxt == SHOW);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (rx_valid && !rx_ready) r_ovf <= 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) r_mem[r_wptr] <= rx_data;
    end

    assign seg_out  = r_seg;
    assign busy     = r_busy;
    assign overflow = r_ovf;
    assign count    = r_count;

endmodule

// File: tb/tb_anthem_char_receiver.sv
// Scoreboard bench for anthem_char_receiver: accepted characters queue their
// expected segment pattern; a monitor checks each displayed run and its length.
module tb_anthem_char_receiver;

    localparam int DEPTH = 8;
    localparam int HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] seg_out;
    logic       busy;
    logic       overflow;
    logic [3:0] count;

    anthem_char_receiver #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .seg_out(seg_out),
        .busy(busy), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] seg; logic contig; } exp_t;
    exp_t sb[$];

    int   n_chk = 0;
    int   n_fail = 0;
    logic in_reset = 1'b1;
    logic next_contig = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a run is a stretch of busy samples with one pattern.
    logic       in_run = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] cur_seg = 8'h00;
    int         run_len = 0;

    always @(negedge clk) begin
        if (in_reset) begin
            in_run    = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (in_run && (!busy || seg_out != cur_seg)) begin
                chk("run_len", run_len, HOLD);
                in_run = 1'b0;
            end
            if (busy && !in_run) begin
                if (sb.size() == 0) begin
                    chk("unexpected_char", {24'h0, seg_out}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("seg", {24'h0, seg_out}, {24'h0, e.seg});
                    chk("contig", {31'h0, prev_busy}, {31'h0, e.contig});
                end
                in_run  = 1'b1;
                cur_seg = seg_out;
                run_len = 0;
            end
            if (in_run && ena) run_len++;
            prev_busy = busy;
        end
    end

    task automatic push(input logic [7:0] ch, input logic [7:0] ex);
        int t = 0;
        @(negedge clk);
        while (!rx_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            chk("push_timeout", 32'h0, 32'h1);
        end else begin
            rx_data  = ch;
            rx_valid = 1'b1;
            sb.push_back('{ex, next_contig});
            next_contig = 1'b1;
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!(count == 0 && !busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", {31'h0, (count == 0 && !busy)}, 32'h1);
    endtask

    string      hx = "/0123456789:ABCDEFG abcdefg-";
    logic [7:0] hx_exp [28] = '{8'hC9, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                                8'h7D, 8'h07, 8'h7F, 8'h6F, 8'hC9, 8'h77, 8'h7C,
                                8'h39, 8'h5E, 8'h79, 8'h71, 8'hC9, 8'h00, 8'h77,
                                8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'hC9, 8'h40};
    string      fl = "-0 a5Zb9";
    logic [7:0] fl_exp [8] = '{8'h40, 8'h3F, 8'h00, 8'h77, 8'h6D, 8'hC9, 8'h7C, 8'h6F};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        // Reset, with a valid character that must be ignored.
        rx_valid = 1'b1;
        rx_data  = 8'h35;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("rst_seg", {24'h0, seg_out}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk("rst_count", {28'h0, count}, 32'h0);
        chk("rst_ready", {31'h0, rx_ready}, 32'h1);
        in_reset = 1'b0;

        // Single character latency: push at edge N, visible after N+1.
        next_contig = 1'b0;
        push(8'h35, 8'h6D);
        @(negedge clk);
        chk("lat_seg_n", {24'h0, seg_out}, 32'h0);
        chk("lat_cnt_n", {28'h0, count}, 32'h1);
        @(negedge clk);
        chk("lat_seg_n1", {24'h0, seg_out}, 32'h6D);
        chk("lat_busy_n1", {31'h0, busy}, 32'h1);
        wait_idle();
        chk("blank_after", {24'h0, seg_out}, 32'h0);

        // Back-to-back "123".
        next_contig = 1'b0;
        push(8'h31, 8'h06);
        push(8'h32, 8'h5B);
        push(8'h33, 8'h4F);
        wait_idle();
        chk("b2b_count", {28'h0, count}, 32'h0);

        // Unsupported, letter and space.
        next_contig = 1'b0;
        push(8'h5A, 8'hC9);
        push(8'h61, 8'h77);
        push(8'h20, 8'h00);
        wait_idle();

        // Full decode sweep under flow control.
        next_contig = 1'b0;
        for (int i = 0; i < 28; i++) push(hx[i], hx_exp[i]);
        wait_idle();

        // Fill with display frozen, then pop while a push is attempted.
        @(posedge clk);
        #1 ena = 1'b0;
        next_contig = 1'b0;
        for (int i = 0; i < 8; i++) push(fl[i], fl_exp[i]);
        @(negedge clk);
        chk("full_count", {28'h0, count}, 32'h8);
        chk("full_ready", {31'h0, rx_ready}, 32'h0);
        chk("full_ovf0", {31'h0, overflow}, 32'h0);
        chk("frozen_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1 ena = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h38;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        chk("pop_full_count", {28'h0, count}, 32'h7);
        chk("pop_full_ovf", {31'h0, overflow}, 32'h1);
        // Freeze mid-display; the monitor counts only enabled cycles.
        repeat (6) @(posedge clk);
        #1 ena = 1'b0;
        repeat (3) @(posedge clk);
        #1 ena = 1'b1;
        wait_idle();
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);

        // Reset mid-display with three characters queued.
        next_contig = 1'b0;
        push(8'h31, 8'h06);
        push(8'h32, 8'h5B);
        push(8'h33, 8'h4F);
        push(8'h34, 8'h66);
        @(negedge clk);
        chk("pre_rst_count", {28'h0, count}, 32'h3);
        @(posedge clk);
        #1 in_reset = 1'b1;
        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h37;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rx_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_seg", {24'h0, seg_out}, 32'h0);
        chk("mid_rst_count", {28'h0, count}, 32'h0);
        chk("mid_rst_ovf", {31'h0, overflow}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_ready", {31'h0, rx_ready}, 32'h1);
        in_reset = 1'b0;

        // Operation resumes after reset.
        next_contig = 1'b0;
        push(8'h45, 8'h79);
        wait_idle();

        chk("sb_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/anthem_char_receiver.md
ANTHEM_CHAR_RECEIVER -- requirements
Module: anthem_char_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter HOLD, default 4, meaning clk cycles each character is displayed (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ena  input  1  display-advance enable.
REQ-006 SHALL have port rx_data  input  8  ASCII character from sender.
REQ-007 SHALL have port rx_valid  input  1  sender asserts rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  block can accept a character this cycle.
REQ-009 SHALL have port seg_out  output  8  registered 7-segment pattern, bit0=a..bit6=g, bit7=dp, active high.
REQ-010 SHALL have port busy  output  1  registered; high while in SHOW state.
REQ-011 SHALL have port overflow  output  1  registered sticky flag; character dropped while full.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  registered FIFO occupancy.

Function
REQ-013 SHALL drive rx_ready = (count != DEPTH), combinationally from registered count only.
REQ-014 SHALL push rx_data into FIFO on a rising edge where rx_valid && rx_ready.
REQ-015 SHALL, when rx_valid && !rx_ready, drop the character, set overflow to 1, leave FIFO unchanged.
REQ-016 SHALL keep overflow at 1 until reset; no other clear.
REQ-017 SHALL refuse a push when full even if a pop occurs in the same cycle (no full-cycle pass-through).
REQ-018 SHALL, on simultaneous push and pop with count not full, leave count unchanged and keep FIFO order.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; count never exceeds DEPTH nor underflows below 0.
REQ-020 SHALL implement display FSM with states IDLE and SHOW.
REQ-021 IDLE: seg_out=8'h00, busy=0; if ena && count!=0, pop head, load seg_out with decode(head), load hold counter with HOLD-1, go SHOW.
REQ-022 SHOW: busy=1, seg_out held; if ena and hold counter != 0, decrement.
REQ-023 SHOW with ena and hold counter == 0: if count!=0 pop next and reload (stay SHOW, no blank cycle); else go IDLE and blank seg_out to 8'h00 on same edge.
REQ-024 SHALL freeze FSM, hold counter and seg_out while ena=0; FIFO push path stays active.
REQ-025 Latency: character pushed into empty FIFO at edge N with ena=1 appears on seg_out after edge N+1.
REQ-026 Each character SHALL be on seg_out exactly HOLD enabled cycles.
REQ-027 decode SHALL map '0'-'9' to 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-028 decode SHALL map 'A'/'a'..'F'/'f' to 77,7C,39,5E,79,71.
REQ-029 decode SHALL map space (8'h20) to 00 and '-' (8'h2D) to 40.
REQ-030 decode SHALL map every other byte to C9 (three bars plus dp marking unsupported).

Reset
REQ-031 On rising edge with rst_n=0: seg_out=8'h00, busy=0, overflow=0, count=0, pointers=0, hold counter=0, state IDLE.
REQ-032 Reset mid-SHOW or with FIFO non-empty SHALL discard all stored characters; rx_valid ignored during reset cycles.
REQ-033 rx_ready SHALL read 1 in the first cycle after reset release.

Verification
REQ-034 Push '5' (8'h35) into empty FIFO, ena=1, HOLD=4 -> seg_out=8'h6D for exactly 4 cycles starting edge N+1, then 8'h00, busy 1 then 0.
REQ-035 Push "1","2","3" back-to-back -> seg_out 06,5B,4F each 4 cycles contiguous, no 00 between, count returns to 0.
REQ-036 ena=0, push 9 characters (DEPTH=8) -> count=8, rx_ready=0 after 8th, 9th dropped, overflow=1 and stays 1 after draining.
REQ-037 Full FIFO, rx_valid=1 during pop cycle -> push refused, count decrements to 7, overflow=1.
REQ-038 Push 'Z' (8'h5A), 'a', ' ' -> seg_out C9, then 77, then 00 with busy=1.
REQ-039 Assert rst_n=0 for one cycle mid-display with count=3 -> next cycle seg_out=00, count=0, overflow=0, busy=0, rx_ready=1.
